// File: rtl/glyph_fetch_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// my_types : shared types and constants for the glyph ROM fetch arbiter.
//   GLYPH_ROM_LATENCY : read latency of char_rom in clocks (rom_addr -> rom_q)
//   GlyphReq          : requester slot assignment on the arbiter ports
// ---------------------------------------------------------------------------
package my_types;

    localparam int GLYPH_ROM_LATENCY = 2;

    typedef enum logic [2:0] {
        REQ_LAG   = 3'd0,
        REQ_RES   = 3'd1,
        REQ_OSD   = 3'd2,
        REQ_SPARE = 3'd3
    } GlyphReq;

endpackage

// File: rtl/glyph_fetch_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// glyph_rr_pick : combinational round-robin selector.
//   req_valid : per-requester request bits
//   ptr       : index where the search begins (wraps modulo NUM_REQ)
//   grant     : one-hot grant of the first valid requester at/after ptr, or 0
//   grant_idx : binary index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module glyph_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/glyph_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// glyph_fetch_arbiter : shares the single-port glyph ROM between the text
// overlay requesters, one read per clock, responses tagged one-hot.
//
// Build option: define GLYPH_ARB_PRIORITY_EN to give requester 0 (lag digits)
// absolute priority; the others then round-robin among themselves.
//
// Ports:
//   clock, reset_n   : pixel clock, asynchronous active-low reset
//   line_start       : start-of-blanking pulse, rewinds the priority pointer
//   req_valid/addr   : per-requester read request, address slice i*ADDR_W
//   req_ready        : combinational one-hot grant (0 while in reset)
//   rom_addr, rom_q  : registered address to char_rom and its read data
//   rsp_valid/data   : one-hot response owner and registered glyph byte
//   inflight         : accepted reads whose response has not yet been issued
// ---------------------------------------------------------------------------
module glyph_fetch_arbiter
    import my_types::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int ROM_LATENCY = GLYPH_ROM_LATENCY
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      line_start,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [2:0]                inflight
);

    localparam int PTR_W = $clog2(NUM_REQ);

`ifdef GLYPH_ARB_PRIORITY_EN
    // Round-robin pointer never rests on the lag-digit slot.
    localparam logic [PTR_W-1:0] PTR_HOME = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_HOME = '0;
`endif

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] pick_valid;
    logic [NUM_REQ-1:0] rr_grant;
    logic [PTR_W-1:0]   rr_idx;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   sel_idx;
    logic               accept;
    logic               retire;

    // tag_pipe[i] holds the one-hot owner of the read accepted i+1 cycles ago
    logic [NUM_REQ-1:0] tag_pipe [ROM_LATENCY+1];

`ifdef GLYPH_ARB_PRIORITY_EN
    assign pick_valid = req_valid & ~(NUM_REQ'(1) << int'(REQ_LAG));
`else
    assign pick_valid = req_valid;
`endif

    glyph_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_valid (pick_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    always_comb begin
        grant    = rr_grant;
        sel_idx  = rr_idx;
        ptr_next = ptr;
`ifdef GLYPH_ARB_PRIORITY_EN
        if (req_valid[int'(REQ_LAG)]) begin
            grant                = '0;
            grant[int'(REQ_LAG)] = 1'b1;
            sel_idx              = PTR_W'(int'(REQ_LAG));
        end else if (|rr_grant) begin
            ptr_next = (int'(rr_idx) == NUM_REQ - 1) ? PTR_HOME : rr_idx + PTR_W'(1);
        end
`else
        if (|rr_grant) begin
            ptr_next = (int'(rr_idx) == NUM_REQ - 1) ? PTR_HOME : rr_idx + PTR_W'(1);
        end
`endif
        // A line start overrides the pointer even when a grant happens too.
        if (line_start) begin
            ptr_next = PTR_HOME;
        end
    end

    assign req_ready = reset_n ? grant : '0;
    assign accept    = |req_ready;
    assign retire    = |tag_pipe[ROM_LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            rom_addr  <= '0;
            tag_pipe  <= '{default: '0};
            rsp_valid <= '0;
            rsp_data  <= '0;
            inflight  <= '0;
        end else begin
            ptr <= ptr_next;

            // Stage: address issue to char_rom
            if (accept) begin
                rom_addr <= req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            end
            tag_pipe[0] <= req_ready;

            // Stage: owner tag follows the ROM read latency
            for (int i = 1; i <= ROM_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            // Stage: response register, rom_q is valid alongside tag_pipe[ROM_LATENCY]
            rsp_valid <= tag_pipe[ROM_LATENCY];
            rsp_data  <= rom_q;

            unique case ({accept, retire})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: doc/glyph_fetch_arbiter.md
# glyph_fetch_arbiter

Shares the single-port character glyph ROM among several text-overlay requesters: lag digits, resolution line, on-screen status and a spare. It accepts one ROM read per clock from the requesters using a valid/ready handshake and issues the address to the ROM. Each glyph byte is returned to the requester that asked for it, tagged one-hot, at a fixed latency. It sits between the per-line text generators and `char_rom`, and replaces each generator driving its own ROM address.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `ADDR_W`, 8: glyph ROM address width.
- `DATA_W`, 8: glyph byte width.
- `ROM_LATENCY`, 2: cycles from `rom_addr` change to valid `rom_q`; legal range 1..4.

Ports:
- `clock`, in, 1: pixel clock; the only clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `line_start`, in, 1: one-cycle pulse at the start of horizontal blanking.
- `req_valid`, in, NUM_REQ: per-requester read request.
- `req_addr`, in, NUM_REQ*ADDR_W: per-requester address; slice i is `[i*ADDR_W +: ADDR_W]`.
- `req_ready`, out, NUM_REQ: one-hot or zero; combinational grant.
- `rom_addr`, out, ADDR_W: registered address to `char_rom`.
- `rom_q`, in, DATA_W: ROM data.
- `rsp_valid`, out, NUM_REQ: one-hot or zero; response owner.
- `rsp_data`, out, DATA_W: registered glyph byte.
- `inflight`, out, 3: number of accepted reads not yet returned.

## Operation
- A request is accepted when `req_valid[i] && req_ready[i]`; at most one acceptance per cycle.
- `req_ready` depends only on `req_valid` and the priority pointer `ptr`. There is no path from `req_addr` to `req_ready`.
- Arbitration is round-robin. Search starts at `ptr` upward and wraps modulo NUM_REQ; the first valid requester is granted. On acceptance of requester g, `ptr <= (g+1) mod NUM_REQ`.
- A requester holds `req_valid` and `req_addr` stable until accepted. It may deassert `req_valid` before acceptance; this is not an error and leaves no state behind.
- On acceptance, `rom_addr <= req_addr[g]`. `rom_addr` holds its value when idle.
- The tag pipeline is a shift register of depth ROM_LATENCY+1 holding the one-hot grant. At its output, `rsp_valid <= tag` and `rsp_data <= rom_q`.
- `line_start` sets `ptr <= 0`. If `line_start` and an acceptance occur in the same cycle, `line_start` wins for `ptr`; the acceptance itself still proceeds.
- `inflight` increments on acceptance and decrements on `rsp_valid`. Both in the same cycle leave it unchanged. The maximum value is ROM_LATENCY+1, so it never wraps.
- Reset, asynchronous and usable mid-operation: `rom_addr`=0, `ptr`=0, tag pipeline cleared, `rsp_valid`=0, `rsp_data`=0, `inflight`=0. In-flight reads are dropped and no response is produced for them. `req_ready` is 0 while `reset_n` is low.

## Timing
- Accept in cycle N. `rom_addr` is valid from cycle N+1. `rom_q` is valid in cycle N+1+ROM_LATENCY. `rsp_valid`/`rsp_data` are valid in cycle N+2+ROM_LATENCY; that is 4 cycles with the default latency.
- Throughput is 1 read/cycle, sustained. Responses return in acceptance order with no bubbles inserted.
- `rsp_valid` is high for exactly one cycle per accepted read. There is no backpressure on responses: the requester must capture the data that cycle.

## Configuration
- `GLYPH_ARB_PRIORITY_EN` defined:
  - Requester 0 (lag digits) has fixed absolute priority. Whenever `req_valid[0]` is high it is granted and `ptr` is unchanged.
  - Requesters 1..NUM_REQ-1 are round-robin among themselves; `ptr` ranges over 1..NUM_REQ-1 and `line_start` sets it to 1.
- `GLYPH_ARB_PRIORITY_EN` undefined: pure round-robin over all requesters as described under Operation.

## Structure
- Package `my_types` holds:
  - `GLYPH_ROM_LATENCY` constant (2).
  - `GlyphReq` enum: `REQ_LAG`=0, `REQ_RES`=1, `REQ_OSD`=2, `REQ_SPARE`=3.
- Sub-module `glyph_rr_pick` contains the combinational round-robin pick: inputs `req_valid`, `ptr`; outputs one-hot `grant` and index `grant_idx`.
- The top level holds `ptr`, the tag pipeline, the `inflight` counter and the `GLYPH_ARB_PRIORITY_EN` muxing.

## Test plan
- Requester 2 alone, addr 0x35, ROM model returns 0xA5 with 2-cycle latency -> `req_ready`=0b0100 in cycle N; `rom_addr`=0x35 at N+1; `rsp_valid`=0b0100 with `rsp_data`=0xA5 at N+4; `inflight` 1 from N+1 through N+3, 0 at N+4.
- All four requesters valid continuously for 8 cycles, priority macro off -> grants 0,1,2,3,0,1,2,3; 8 responses in the same order; `inflight` peaks at 3.
- Priority macro on, requesters 0 and 1 valid for 3 cycles, then 1 and 2 -> grants 0,0,0,1,2,1.
- After grant to requester 2, pulse `line_start` -> next grant with 1 and 3 valid goes to 1 rather than 3.
- Three reads in flight, then `reset_n` low for 1 cycle -> all outputs 0 immediately; no `rsp_valid` afterwards; `ptr`=0.
- Requester 3 valid for 1 cycle while requester 0 holds the grant, then deasserts -> no response for requester 3 ever; `inflight` counts only requester 0's reads.
